// File: rtl/ttfir_mac_core_if.sv
// ttfir_mac_core_if: sample/coefficient input bus and filtered output bus of the FIR core
interface ttfir_mac_core_if #(
   parameter int BW_DIN = 6,
   parameter int BW_OUT = 8
);
   logic load;
   logic din_valid;
   logic signed [BW_DIN-1:0] din;
   logic din_ready;
   logic signed [BW_OUT-1:0] dout;
   logic dout_valid;
   logic sat;
   modport master (output load, din_valid, din, input din_ready, dout, dout_valid, sat);
   modport slave (input load, din_valid, din, output din_ready, dout, dout_valid, sat);
endinterface

// File: rtl/ttfir_mac_core.sv
// ttfir_mac_core: time-multiplexed FIR, one MAC iterating over streamed-in taps
module ttfir_mac_core #(
   parameter int N_TAPS = 4,
   parameter int BW_IN = 6,
   parameter int BW_COEF = 6,
   parameter int BW_OUT = 8,
   parameter int SHIFT = 5
) (
   input logic clk,
   input logic reset,
   ttfir_mac_core_if.slave bus
);
   localparam int PW = BW_IN + BW_COEF;
   localparam int BW_ACC = PW + $clog2(N_TAPS);
   localparam int TW = $clog2(N_TAPS);
   localparam logic signed [BW_ACC:0] HALF = 2 ** (SHIFT - 1);
   localparam logic signed [BW_ACC:0] OMAX = 2 ** (BW_OUT - 1) - 1;
   localparam logic signed [BW_ACC:0] OMIN = -(2 ** (BW_OUT - 1));
   typedef enum logic [1:0] {LOAD, RUN_IDLE, MAC} state_t;
   state_t state, state_nxt;
   logic signed [BW_COEF-1:0] coef [N_TAPS];
   logic signed [BW_IN-1:0] x [N_TAPS];
   logic signed [BW_ACC-1:0] acc, sum;
   logic signed [PW-1:0] prod;
   logic signed [BW_ACC:0] rnd, r;
   logic [TW-1:0] count, tap;
   logic accept, last;
   assign bus.din_ready = state != MAC;
   assign accept = bus.din_valid && bus.din_ready;
   assign last = tap == TW'(N_TAPS - 1);
   assign prod = coef[tap] * x[tap];
   assign sum = acc + {{(BW_ACC - PW){prod[PW-1]}}, prod};
   // extra headroom bit so the rounding offset can never wrap the full-precision sum
   assign rnd = {sum[BW_ACC-1], sum} + HALF;
   assign r = rnd >>> SHIFT;
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: if (accept && bus.load && count == TW'(N_TAPS - 1)) state_nxt = RUN_IDLE;
         RUN_IDLE: if (accept && bus.load) state_nxt = LOAD; else if (accept) state_nxt = MAC;
         default: if (last) state_nxt = RUN_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
         count <= '0;
         tap <= '0;
         acc <= '0;
         bus.dout <= '0;
         bus.sat <= 1'b0;
         bus.dout_valid <= 1'b0;
         for (int k = 0; k < N_TAPS; k++) begin
            coef[k] <= '0;
            x[k] <= '0;
         end
      end else begin
         state <= state_nxt;
         bus.dout_valid <= 1'b0;
         if (accept && bus.load) begin
            coef[0] <= bus.din[BW_COEF-1:0];
            for (int k = 1; k < N_TAPS; k++) coef[k] <= coef[k-1];
            count <= state == LOAD ? count + TW'(1) : TW'(1);
            // a reload starts a fresh stream: stale history must not leak into it
            if (state == RUN_IDLE) for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
         end
         if (accept && !bus.load && state == RUN_IDLE) begin
            x[0] <= bus.din[BW_IN-1:0];
            for (int k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            tap <= '0;
         end
         if (state == MAC) begin
            acc <= sum;
            tap <= tap + TW'(1);
            if (last) begin
               bus.dout <= r > OMAX ? OMAX[BW_OUT-1:0] : r < OMIN ? OMIN[BW_OUT-1:0] : r[BW_OUT-1:0];
               bus.sat <= r > OMAX || r < OMIN;
               bus.dout_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ttfir_mac_core.sv
// tb_ttfir_mac_core: directed scenarios with a scoreboard of expected dout/sat per sample
module tb_ttfir_mac_core;
   typedef struct {
      logic signed [7:0] d;
      logic s;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0;
   int total = 0;
   exp_t q[$];
   exp_t mon_e;
   ttfir_mac_core_if #(.BW_DIN(6), .BW_OUT(8)) bus ();
   ttfir_mac_core dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask
   task automatic send(input logic ld, input logic signed [5:0] v);
      logic r;
      int n;
      n = 0;
      bus.load = ld;
      bus.din = v;
      bus.din_valid = 1'b1;
      do begin
         @(negedge clk);
         r = bus.din_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 50);
      bus.din_valid = 1'b0;
      chk("accept", r, 1);
   endtask
   task automatic sample(input logic signed [5:0] v, input logic signed [7:0] d, input logic s);
      q.push_back('{d, s});
      send(1'b0, v);
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", q.size(), 0);
   endtask
   always @(negedge clk) begin
      if (!reset && bus.dout_valid) begin
         chk("ready_with_valid", bus.din_ready, 1);
         if (q.size() == 0) chk("unexpected_valid", bus.dout_valid, 0);
         else begin
            mon_e = q.pop_front();
            chk("dout", bus.dout, mon_e.d);
            chk("sat", bus.sat, mon_e.s);
         end
      end
   end
   initial begin
      bus.load = 1'b1;
      bus.din = 6'sd5;
      bus.din_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      bus.din_valid = 1'b0;
      @(negedge clk);
      chk("rst_ready", bus.din_ready, 1);
      chk("rst_dout", bus.dout, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_valid", bus.dout_valid, 0);
      @(posedge clk);
      #1;
      send(1'b0, 6'sd9);
      send(1'b1, 6'sd1);
      send(1'b1, 6'sd2);
      send(1'b1, 6'sd3);
      send(1'b1, 6'sd4);
      sample(6'sd16, 8'sd2, 1'b0);
      sample(6'sd0, 8'sd2, 1'b0);
      sample(6'sd0, 8'sd1, 1'b0);
      sample(6'sd0, 8'sd1, 1'b0);
      sample(6'sd0, 8'sd0, 1'b0);
      drain();
      repeat (4) send(1'b1, -6'sd32);
      sample(-6'sd32, 8'sd32, 1'b0);
      sample(-6'sd32, 8'sd64, 1'b0);
      sample(-6'sd32, 8'sd96, 1'b0);
      sample(-6'sd32, 8'sd127, 1'b1);
      sample(6'sd0, 8'sd96, 1'b0);
      drain();
      send(1'b1, 6'sd0);
      send(1'b1, 6'sd0);
      send(1'b1, 6'sd0);
      send(1'b1, -6'sd1);
      sample(6'sd16, 8'sd0, 1'b0);
      sample(6'sd17, -8'sd1, 1'b0);
      sample(-6'sd16, 8'sd1, 1'b0);
      drain();
      repeat (3) q.push_back('{-8'sd1, 1'b0});
      bus.load = 1'b0;
      bus.din = 6'sd17;
      bus.din_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("hs_ready", bus.din_ready, (i % 5 == 0) ? 1 : 0);
      end
      bus.din_valid = 1'b0;
      drain();
      send(1'b1, 6'sd0);
      send(1'b0, 6'sd7);
      send(1'b1, 6'sd0);
      send(1'b1, 6'sd0);
      send(1'b1, 6'sd2);
      sample(6'sd16, 8'sd1, 1'b0);
      drain();
      send(1'b0, 6'sd20);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_dout", bus.dout, 0);
      chk("abort_sat", bus.sat, 0);
      chk("abort_ready", bus.din_ready, 1);
      chk("abort_valid", bus.dout_valid, 0);
      repeat (6) @(posedge clk);
      #1;
      send(1'b0, 6'sd31);
      repeat (4) send(1'b1, 6'sd1);
      sample(6'sd31, 8'sd1, 1'b0);
      drain();
      repeat (4) send(1'b1, 6'sd0);
      sample(6'sd31, 8'sd0, 1'b0);
      drain();
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
